stopwatch_buttons: RTL

//   Control front end for the stopwatch: conditions the raw active-low badge

---
 rtl/stopwatch_buttons.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_buttons.sv
// stopwatch_buttons: control front end for the stopwatch.
//   Conditions the three active-low badge buttons (invert, 2-flop sync, debounce, press strobe)
//   and runs the STOP/RUN/PAUSE state machine plus the lap-display hold timer.
// Ports:
//   clk, rst                          system clock, synchronous active-high reset
//   nbtn_start, nbtn_lap, nbtn_clear  raw active-low buttons, asynchronous to clk
//   tick                              one-cycle 1/100 s pulse
//   running                           high while in RUN
//   count_en                          running & tick, increments the BCD time counter
//   clear                             one-cycle strobe: zero time counter and lap register
//   lap_capture                       one-cycle strobe: copy current time into lap register
//   lap_show                          high while the lap hold timer is nonzero
module stopwatch_buttons #(
  parameter int unsigned DEBOUNCE_CYCLES = 80000,
  parameter int unsigned LAP_HOLD_TICKS  = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic nbtn_start,
  input  logic nbtn_lap,
  input  logic nbtn_clear,
  input  logic tick,
  output logic running,
  output logic count_en,
  output logic clear,
  output logic lap_capture,
  output logic lap_show
);

  localparam int unsigned BtnStart = 0;
  localparam int unsigned BtnLap   = 1;
  localparam int unsigned BtnClear = 2;

  localparam logic [16:0] DbLast  = 17'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]  LapHold = 5'(LAP_HOLD_TICKS);

  typedef enum logic [1:0] {StStop, StRun, StPause} state_e;

  // Button conditioning state, one bit per button.
  logic [2:0]  btn_raw;
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  stable_q, stable_d;
  logic [2:0]  stable_prev_q;
  logic [2:0]  press_q, press_d;
  logic [16:0] db_cnt_q [3];
  logic [16:0] db_cnt_d [3];

  // Control state.
  state_e     state_q, state_d;
  logic [4:0] lap_timer_q, lap_timer_d;
  logic       clear_q, clear_d;
  logic       lap_capture_q, lap_capture_d;
  logic       lap_show_q, lap_show_d;
  logic       clear_ok;

  assign btn_raw = ~{nbtn_clear, nbtn_lap, nbtn_start};

  // Debounce: stable follows the synchronized level only after it has differed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 17'd1;
        end
      end
    end
  end

  // Press strobe on the registered 0->1 of the debounced level.
  assign press_d = stable_q & ~stable_prev_q;

  // Clear is honoured only outside RUN, and then overrides a same-cycle start.
  assign clear_ok = press_q[BtnClear] && (state_q != StRun);

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StStop;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    if (clear_ok) begin
      state_d = StStop;
    end else if (press_q[BtnStart]) begin
      unique case (state_q)
        StStop:  state_d = StRun;
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
        default: state_d = StStop;
      endcase
    end
  end

  // FSM: outputs and lap hold timer. Lap decisions use the pre-transition state.
  always_comb begin
    clear_d       = clear_ok;
    lap_capture_d = press_q[BtnLap] && (state_q == StRun);
    lap_timer_d   = lap_timer_q;
    if (press_q[BtnLap] && (state_q == StRun)) begin
      lap_timer_d = LapHold;
    end else if ((press_q[BtnLap] && (state_q == StPause)) || clear_ok) begin
      lap_timer_d = '0;
    end else if (tick && (lap_timer_q != 5'd0)) begin
      lap_timer_d = lap_timer_q - 5'd1;
    end
    lap_show_d = (lap_timer_d != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      press_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
      lap_timer_q   <= '0;
      clear_q       <= 1'b0;
      lap_capture_q <= 1'b0;
      lap_show_q    <= 1'b0;
    end else begin
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      press_q       <= press_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      lap_timer_q   <= lap_timer_d;
      clear_q       <= clear_d;
      lap_capture_q <= lap_capture_d;
      lap_show_q    <= lap_show_d;
    end
  end

  assign running     = (state_q == StRun);
  assign count_en    = running & tick;
  assign clear       = clear_q;
  assign lap_capture = lap_capture_q;
  assign lap_show    = lap_show_q;

endmodule
